// File: rtl/dmem_resp.sv
// Data-memory responder: one load/store at a time on a byte-enabled word RAM,
// returning an aligned/extended load result or store completion on a one-cycle strobe.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request; req_ready_o high unless in reset
// ACCESS | RAM write commits / RAM read sampled into response regs
// RESP   | rsp_valid_o high for this one cycle
module dmem_resp #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_op_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t state, state_nxt;

    logic [31:0]   ram [DEPTH_WORDS];

    logic [AW-1:0] idx_q;
    logic [1:0]    lane_q;
    logic [31:0]   data_q;
    logic [3:0]    op_q;
    logic          err_q;

    logic          hs;
    logic          is_load, is_store, bad_align, bad_op, out_of_range, req_err;
    logic          ram_we;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   shifted;
    logic [31:0]   load_val;

    assign req_ready_o = (state == S_IDLE) && !rst_i;
    assign hs          = req_valid_i && req_ready_o;

    // Request classification and error decision, evaluated at handshake time.
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        bad_align = 1'b0;
        bad_op    = 1'b0;
        case (mem_op_i)
            OP_NOP: ;
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin
                is_load   = 1'b1;
                bad_align = mem_addr_i[0];
            end
            OP_LW: begin
                is_load   = 1'b1;
                bad_align = |mem_addr_i[1:0];
            end
            OP_SB: is_store = 1'b1;
            OP_SH: begin
                is_store  = 1'b1;
                bad_align = mem_addr_i[0];
            end
            OP_SW: begin
                is_store  = 1'b1;
                bad_align = |mem_addr_i[1:0];
            end
            default: bad_op = 1'b1;
        endcase
        out_of_range = mem_addr_i[31:2] >= 30'(DEPTH_WORDS);
        req_err = (mem_op_i != OP_NOP) &&
                  (bad_op || bad_align || out_of_range ||
                   (mem_we_i && is_load) || (!mem_we_i && is_store));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (hs) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            lane_q <= '0;
            data_q <= '0;
            op_q   <= OP_NOP;
            err_q  <= 1'b0;
        end else if (hs) begin
            idx_q  <= mem_addr_i[AW+1:2];
            lane_q <= mem_addr_i[1:0];
            data_q <= mem_data_i;
            op_q   <= mem_op_i;
            err_q  <= req_err;
        end
    end

    // Store lane enables; narrow data is replicated so each lane sees its byte.
    always_comb begin
        be    = 4'b0000;
        wdata = data_q;
        case (op_q)
            OP_SB: begin
                be    = 4'b0001 << lane_q;
                wdata = {4{data_q[7:0]}};
            end
            OP_SH: begin
                be    = lane_q[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data_q[15:0]}};
            end
            OP_SW: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Reset at the ACCESS edge cancels the write.
    assign ram_we = (state == S_ACCESS) && !rst_i && !err_q;

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram[idx_q][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        shifted = ram[idx_q] >> {lane_q, 3'b000};
        case (op_q)
            OP_LB:   load_val = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_val = {24'h0, shifted[7:0]};
            OP_LH:   load_val = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_val = {16'h0, shifted[15:0]};
            OP_LW:   load_val = shifted;
            default: load_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= 1'b0;
        end else if (state == S_ACCESS) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= err_q;
            rsp_rdata_o <= err_q ? 32'h0 : load_val;
        end else begin
            rsp_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dmem_resp.sv
// Directed self-checking bench for dmem_resp: load/store formatting, errors,
// back-to-back throughput and reset mid-operation.
module tb_dmem_resp;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_data = '0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_op = 4'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int vectors = 0;
    int misses  = 0;

    dmem_resp #(.DEPTH_WORDS(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .mem_addr_i(mem_addr), .mem_data_i(mem_data),
        .mem_we_i(mem_we), .mem_op_i(mem_op),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic issue(input logic [3:0] op, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, output logic [31:0] rdata,
                         output logic err, output int lat, output logic [2:0] rdy_seen);
        bit got;
        @(negedge clk);
        mem_op = op; mem_we = we; mem_addr = addr; mem_data = data; req_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (req_ready) got = 1;
            @(posedge clk);
            if (!got) @(negedge clk);
        end
        lat = -1; rdata = 'x; err = 1'bx; rdy_seen = '0;
        if (!got) begin
            vectors++; misses++;
            $display("FAIL handshake_timeout op=%0d got=no want=yes", op);
            req_valid = 1'b0;
            return;
        end
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) req_valid = 1'b0;
            if (i <= 3) rdy_seen[i-1] = req_ready;
            if (rsp_valid && lat < 0) begin
                lat = i; rdata = rsp_rdata; err = rsp_err;
            end
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            misses++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== 35'h0) begin
            misses++;
            $display("FAIL reset_outputs got=%b/%b/%b/%h want=0/0/0/0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            misses++;
            $display("FAIL reset_ready_after got=%b want=1", req_ready);
        end
    endtask

    task automatic test_word;
        logic [31:0] rd; logic er; int lat; logic [2:0] rdy;
        issue(4'd8, 1'b1, 32'h10, 32'h8765_4321, rd, er, lat, rdy);
        chk32("sw_lat", 32'(lat), 32'd2);
        chk32("sw_ready_pattern", {29'h0, rdy}, 32'b100);
        chk32("sw_rsp", {rd[30:0], er}, 32'h0);
        issue(4'd3, 1'b0, 32'h10, 32'h0, rd, er, lat, rdy);
        chk32("lw_lat", 32'(lat), 32'd2);
        chk32("lw_ready_pattern", {29'h0, rdy}, 32'b100);
        chk32("lw_data", rd, 32'h8765_4321);
        chk32("lw_err", {31'h0, er}, 32'h0);
    endtask

    task automatic test_subword;
        logic [31:0] rd; logic er; int lat; logic [2:0] rdy;
        logic [3:0]  ops  [5] = '{4'd3, 4'd1, 4'd4, 4'd2, 4'd5};
        logic [31:0] adrs [5] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12};
        logic [31:0] exp  [5] = '{32'hF065_4321, 32'hFFFF_FFF0, 32'h0000_00F0,
                                  32'hFFFF_F065, 32'h0000_F065};
        issue(4'd6, 1'b1, 32'h13, 32'h1234_56F0, rd, er, lat, rdy);
        chk32("sb_err", {31'h0, er}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], 1'b0, adrs[i], 32'h0, rd, er, lat, rdy);
            chk32($sformatf("load%0d_data", i), rd, exp[i]);
            chk32($sformatf("load%0d_err", i), {31'h0, er}, 32'h0);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat; logic [2:0] rdy;
        logic [3:0]  ops  [5] = '{4'd2, 4'd8, 4'd6, 4'd1, 4'd12};
        logic        wes  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] adrs [5] = '{32'h11, 32'h12, 32'(4*DEPTH), 32'h10, 32'h10};
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], wes[i], adrs[i], 32'hDEAD_BEEF, rd, er, lat, rdy);
            chk32($sformatf("err%0d_flag", i), {31'h0, er}, 32'h1);
            chk32($sformatf("err%0d_rdata", i), rd, 32'h0);
            issue(4'd3, 1'b0, 32'h10, 32'h0, rd, er, lat, rdy);
            chk32($sformatf("err%0d_after_lw", i), rd, 32'hF065_4321);
        end
    endtask

    task automatic test_nop;
        logic [31:0] rd; logic er; int lat; logic [2:0] rdy;
        issue(4'd0, 1'b1, 32'hFFFF_FFFF, 32'h5555_5555, rd, er, lat, rdy);
        chk32("nop_lat", 32'(lat), 32'd2);
        chk32("nop_err", {31'h0, er}, 32'h0);
        chk32("nop_rdata", rd, 32'h0);
        issue(4'd3, 1'b0, 32'h10, 32'h0, rd, er, lat, rdy);
        chk32("nop_after_lw", rd, 32'hF065_4321);
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ops  [4] = '{4'd3, 4'd4, 4'd5, 4'd1};
        logic [31:0] adrs [4] = '{32'h10, 32'h13, 32'h12, 32'h11};
        logic [31:0] exp  [4] = '{32'hF065_4321, 32'h0000_00F0, 32'h0000_F065, 32'h0000_0043};
        int k = 0, n = 0, last = -1;
        bit hs;
        @(negedge clk);
        mem_we = 1'b0; mem_op = ops[0]; mem_addr = adrs[0]; req_valid = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            hs = req_valid && req_ready;
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid) begin
                if (n < 4) begin
                    chk32($sformatf("b2b%0d_data", n), rsp_rdata, exp[n]);
                    if (last >= 0) chk32($sformatf("b2b%0d_spacing", n), 32'(cyc - last), 32'd3);
                end
                n++; last = cyc;
            end
            if (hs) begin
                k++;
                if (k < 4) begin
                    mem_op = ops[k]; mem_addr = adrs[k];
                end else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        chk32("b2b_count", 32'(n), 32'd4);
    endtask

    task automatic test_reset_mid_store;
        logic [31:0] rd; logic er; int lat; logic [2:0] rdy;
        bit saw_rsp = 0, bad_out = 0, got = 0;
        issue(4'd8, 1'b1, 32'h20, 32'h1122_3344, rd, er, lat, rdy);
        @(negedge clk);
        mem_op = 4'd8; mem_we = 1'b1; mem_addr = 32'h20; mem_data = 32'hAAAA_AAAA;
        req_valid = 1'b1;
        for (int i = 0; i < 6 && !got; i++) begin
            if (req_ready) got = 1;
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1;
            if (req_ready || rsp_valid || rsp_err || rsp_rdata != 0) bad_out = 1;
        end
        rst = 1'b0;
        @(negedge clk);
        chk32("rst_handshake", {31'h0, got}, 32'h1);
        chk32("rst_no_rsp", {31'h0, saw_rsp}, 32'h0);
        chk32("rst_outputs_zero", {31'h0, bad_out}, 32'h0);
        chk32("rst_ready_after", {31'h0, req_ready}, 32'h1);
        issue(4'd3, 1'b0, 32'h20, 32'h0, rd, er, lat, rdy);
        chk32("rst_old_contents", rd, 32'h1122_3344);
    endtask

    initial begin
        test_reset;
        test_word;
        test_subword;
        test_errors;
        test_nop;
        test_back_to_back;
        test_reset_mid_store;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the single-issue RISC-V core: the far end of the execute stage's memory request port (`mem_addr`, `mem_data`, `mem_we`, `mem_op`). It accepts one load or store request at a time and performs it on an internal word-organised, byte-enabled synchronous RAM. It returns a load result that has been byte/halfword aligned and sign- or zero-extended, or a store completion, on a one-cycle response strobe. It also flags misaligned, out-of-range and inconsistent requests.

## Interface
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words (4 KiB); power of two.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  block can accept; request transfers when `req_valid_i & req_ready_o`.
- `mem_addr_i`  in  32  byte address.
- `mem_data_i`  in  32  store data; the low byte/halfword is used for SB/SH.
- `mem_we_i`  in  1  1 = store, 0 = load; must agree with `mem_op_i` class.
- `mem_op_i`  in  4  NOP=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8; 9–15 undefined.
- `rsp_valid_o`  out  1  one-cycle response strobe.
- `rsp_rdata_o`  out  32  load result; 0 for stores, NOP and errors.
- `rsp_err_o`  out  1  request rejected; no RAM access was made.

## Operation
- FSM states: IDLE, ACCESS, RESP. Transitions:
  - IDLE→ACCESS on a handshake.
  - ACCESS→RESP unconditionally.
  - RESP→IDLE unconditionally.
- `req_ready_o` = 1 only in IDLE with `rst_i`=0.
- On handshake, latch addr, data, op, we and the error decision.
- Error conditions. Any one sets `rsp_err_o`=1, forces `rsp_rdata_o`=0 and suppresses the RAM write:
  - LH/LHU/SH with `addr[0]`=1.
  - LW/SW with `addr[1:0]`≠0.
  - `addr[31:2]` ≥ `DEPTH_WORDS` for any non-NOP op.
  - `mem_we_i`=1 with a load op.
  - `mem_we_i`=0 with a store op.
  - op 9–15.
- NOP (op 0): accepted, no access, `rsp_err_o`=0, `rsp_rdata_o`=0, regardless of `mem_we_i` and address.
- Byte order is little-endian. Word index is `addr[31:2]`; lane is `addr[1:0]`.
- Stores: write happens in ACCESS.
  - SB: byte enable = 1 << `addr[1:0]`; data byte is replicated to all lanes.
  - SH: byte enable = 0011 or 1100 by `addr[1]`.
  - SW: byte enable = 1111.
- Loads: RAM read is issued in ACCESS. In the RESP transition the word is shifted right by 8·`addr[1:0]`, then:
  - LB: sign-extend bit 7.
  - LBU: zero-extend 8 bits.
  - LH: sign-extend bit 15.
  - LHU: zero-extend 16 bits.
  - LW: unchanged.
- RAM contents are not reset and are undefined until written.

## Timing
- Handshake at edge T. ACCESS during cycle T→T+1; store write commits at edge T+1.
- `rsp_valid_o`=1 during cycle T+1→T+2 (RESP) only. `rsp_rdata_o` and `rsp_err_o` are valid in that cycle and hold their value until the next response.
- `req_ready_o` returns to 1 at T+2. Maximum throughput is one request per 3 cycles.
- A load issued right after a store to the same word returns the new data; no forwarding is needed because the store completes before the load's ACCESS.
- Reset: state = IDLE, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, `req_ready_o`=0 while `rst_i`=1 and 1 on the first cycle after.
- Reset mid-operation: the pending request is dropped with no response. A store whose ACCESS edge coincides with `rst_i`=1 must not write.
- `req_valid_i` while not ready is ignored. The requester holds its request until the handshake.

## Test plan
- SW 0x8765_4321 to 0x10, then LW 0x10 → `rsp_rdata_o`=0x8765_4321, `rsp_err_o`=0. The response comes 2 cycles after each handshake, and ready is low for exactly 2 cycles.
- SB 0xF0 to 0x13 over that word, then:
  - LW 0x10 → 0xF065_4321.
  - LB 0x13 → 0xFFFF_FFF0.
  - LBU 0x13 → 0x0000_00F0.
  - LH 0x12 → 0xFFFF_F065.
  - LHU 0x12 → 0x0000_F065.
- Error cases, each → `rsp_err_o`=1, rdata 0; a following LW 0x10 is unchanged:
  - LH 0x11.
  - SW 0x12.
  - SB to address 4·`DEPTH_WORDS`.
  - `mem_we_i`=1 with op LB.
  - op 12.
- NOP with `mem_we_i`=1 and address 0xFFFF_FFFF → `rsp_valid_o` pulse, `rsp_err_o`=0, rdata 0, no RAM change.
- Hold `req_valid_i`=1 continuously with 4 queued loads → exactly 4 responses at 3-cycle spacing, in order.
- SW 0xAAAA_AAAA to 0x20 with `rst_i` asserted at edge T+1 → no response; a later LW 0x20 returns the old contents. Outputs read 0 during reset and ready rises the cycle after reset.
